// File: rtl/pe_seq_pkg.sv
// Shared types and constants for the vector MAC PE sequencer:
// FSM state encoding, default lane geometry and flush depth.
package pe_seq_pkg;

    localparam int DEF_REG_WIDTH = 16;
    localparam int DEF_VECTOR    = 8;
    localparam int FLUSH_CYC     = 2;
    localparam int FLUSH_W       = $clog2(FLUSH_CYC);

    typedef logic [DEF_VECTOR-1:0][DEF_REG_WIDTH-1:0] lane_vec_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        FLUSH = 2'd2,
        HOLD  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/pe_seq_cmux.sv
// Accumulator input mux (zero on the first step, PE feedback otherwise)
// and the result capture register loaded by the sequencer FSM.
module pe_seq_cmux #(
    parameter int REG_WIDTH = 16,
    parameter int VECTOR    = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             first_d,
    input  logic                             cap_en,
    input  logic [VECTOR-1:0][REG_WIDTH-1:0] pe_c,
    output logic [VECTOR-1:0][REG_WIDTH-1:0] pe_c_in,
    output logic [VECTOR-1:0][REG_WIDTH-1:0] res
);

    // Feedback select: the PE must see zero while step-0 operands are at its inputs.
    always_comb begin
        pe_c_in = pe_c;
        if (first_d) begin
            pe_c_in = '0;
        end else begin
            pe_c_in = pe_c;
        end
    end

    // Result capture register, loaded once per run when the last sum is visible.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res <= '0;
        end else if (cap_en) begin
            res <= pe_c;
        end else begin
            res <= res;
        end
    end

endmodule

// File: rtl/pe_v8_mac_sequencer.sv
// K-step dot-product sequencer for an 8-lane MAC PE: operand read issue, flush, result handoff.
// Optional performance counters are enabled by defining PE_SEQ_PERF_CNT_EN.
module pe_v8_mac_sequencer
    import pe_seq_pkg::*;
#(
    parameter int REG_WIDTH = DEF_REG_WIDTH,
    parameter int VECTOR    = DEF_VECTOR,
    parameter int K_MAX     = 256,
    parameter int ADDR_W    = $clog2(K_MAX)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic [ADDR_W-1:0]                k_len,
    output logic                             rd_en,
    output logic [ADDR_W-1:0]                a_addr,
    output logic [ADDR_W-1:0]                b_addr,
    input  logic [VECTOR-1:0][REG_WIDTH-1:0] pe_c,
    output logic [VECTOR-1:0][REG_WIDTH-1:0] pe_c_in,
    output logic [VECTOR-1:0][REG_WIDTH-1:0] res,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic                             busy,
    output logic                             done
`ifdef PE_SEQ_PERF_CNT_EN
    ,
    output logic [31:0]                      perf_busy_cyc,
    output logic [15:0]                      perf_runs
`endif
);

    seq_state_t          state;
    logic [ADDR_W-1:0]   cnt;
    logic [ADDR_W-1:0]   k_reg;
    logic                first_d;
    logic [FLUSH_W-1:0]  fcnt;
    logic                cap_en;

    localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(FLUSH_CYC - 1);

    assign a_addr = cnt;
    assign b_addr = cnt;
    assign busy   = (state != IDLE);
    assign done   = (state == HOLD) && out_valid && out_ready;
    assign cap_en = (state == FLUSH) && (fcnt == FLUSH_LAST);

    // Main sequencer FSM: step counter, read strobe, flush timing and handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            k_reg     <= '0;
            first_d   <= 1'b0;
            fcnt      <= '0;
            rd_en     <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            // Step-0 operands arrive one cycle after the step-0 read.
            first_d <= (state == ISSUE) && (cnt == '0);
            case (state)
                IDLE: begin
                    if (start) begin
                        k_reg <= k_len;
                        cnt   <= '0;
                        rd_en <= 1'b1;
                        state <= ISSUE;
                    end else begin
                        state <= IDLE;
                    end
                end
                ISSUE: begin
                    if (cnt == k_reg) begin
                        rd_en <= 1'b0;
                        fcnt  <= '0;
                        state <= FLUSH;
                    end else begin
                        cnt   <= cnt + ADDR_W'(1);
                        rd_en <= 1'b1;
                    end
                end
                FLUSH: begin
                    if (fcnt == FLUSH_LAST) begin
                        fcnt      <= '0;
                        out_valid <= 1'b1;
                        state     <= HOLD;
                    end else begin
                        fcnt <= fcnt + FLUSH_W'(1);
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        out_valid <= 1'b1;
                    end
                end
                default: begin
                    rd_en     <= 1'b0;
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    pe_seq_cmux #(
        .REG_WIDTH (REG_WIDTH),
        .VECTOR    (VECTOR)
    ) u_cmux (
        .clk     (clk),
        .rst_n   (rst_n),
        .first_d (first_d),
        .cap_en  (cap_en),
        .pe_c    (pe_c),
        .pe_c_in (pe_c_in),
        .res     (res)
    );

`ifdef PE_SEQ_PERF_CNT_EN
    // Saturating activity counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_busy_cyc <= 32'd0;
            perf_runs     <= 16'd0;
        end else begin
            if (busy && (perf_busy_cyc != 32'hFFFF_FFFF)) begin
                perf_busy_cyc <= perf_busy_cyc + 32'd1;
            end else begin
                perf_busy_cyc <= perf_busy_cyc;
            end
            if (done && (perf_runs != 16'hFFFF)) begin
                perf_runs <= perf_runs + 16'd1;
            end else begin
                perf_runs <= perf_runs;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pe_v8_mac_sequencer.sv
// Bench for pe_v8_mac_sequencer: behavioural PE and operand buffers around the DUT,
// dot products predicted from operand tables and compared after each run.
module tb_pe_v8_mac_sequencer;
    import pe_seq_pkg::*;

    localparam int RW = 16;
    localparam int VN = 8;
    localparam int AW = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic [AW-1:0]   k_len;
    logic            rd_en;
    logic [AW-1:0]   a_addr;
    logic [AW-1:0]   b_addr;
    lane_vec_t       pe_c;
    lane_vec_t       pe_c_in;
    lane_vec_t       res;
    logic            out_valid;
    logic            out_ready;
    logic            busy;
    logic            done;
`ifdef PE_SEQ_PERF_CNT_EN
    logic [31:0]     perf_busy_cyc;
    logic [15:0]     perf_runs;
`endif

    int n_cmp = 0;
    int n_err = 0;

    lane_vec_t mem_a [256];
    lane_vec_t mem_b [256];
    lane_vec_t a_q, b_q;

    always #5 clk = ~clk;

    pe_v8_mac_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .k_len     (k_len),
        .rd_en     (rd_en),
        .a_addr    (a_addr),
        .b_addr    (b_addr),
        .pe_c      (pe_c),
        .pe_c_in   (pe_c_in),
        .res       (res),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
`ifdef PE_SEQ_PERF_CNT_EN
        ,
        .perf_busy_cyc (perf_busy_cyc),
        .perf_runs     (perf_runs)
`endif
    );

    // Operand buffers (1-cycle read latency) and the registered MAC PE.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            a_q <= mem_a[a_addr];
            b_q <= mem_b[b_addr];
        end
        for (int l = 0; l < VN; l++) begin
            pe_c[l] <= RW'(a_q[l] * b_q[l] + pe_c_in[l]);
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // mode 0 random, 1 A=3 B=5, 2 A lane i=i+1 B=2, 3 A=B=0x0100
    task automatic fill(input int k, input int mode, output lane_vec_t exp);
        int unsigned acc [VN];
        for (int l = 0; l < VN; l++) acc[l] = 0;
        for (int i = 0; i <= k; i++) begin
            for (int l = 0; l < VN; l++) begin
                case (mode)
                    1:       begin mem_a[i][l] = 16'd3;         mem_b[i][l] = 16'd5;      end
                    2:       begin mem_a[i][l] = RW'(l + 1);    mem_b[i][l] = 16'd2;      end
                    3:       begin mem_a[i][l] = 16'h0100;      mem_b[i][l] = 16'h0100;   end
                    default: begin mem_a[i][l] = RW'($urandom); mem_b[i][l] = RW'($urandom); end
                endcase
                acc[l] = acc[l] + int'(mem_a[i][l]) * int'(mem_b[i][l]);
            end
        end
        for (int l = 0; l < VN; l++) exp[l] = RW'(acc[l] % 65536);
    endtask

    // One complete run; caller is at an idle cycle. Ends in the cycle after done.
    task automatic do_run(input int k, input int mode, input int hold, input bit glitch);
        lane_vec_t exp;
        int cyc, rd_cnt;
        bit addr_ok, early_done;
        fill(k, mode, exp);
        k_len = AW'(k);
        start = 1'b1;
        out_ready = 1'b0;
        step();
        start = 1'b0;
        cyc = 1; rd_cnt = 0; addr_ok = 1'b1; early_done = 1'b0;
        while (!out_valid && cyc < k + 20) begin
            if (rd_en) begin
                if (a_addr != AW'(rd_cnt) || b_addr != AW'(rd_cnt) || cyc != rd_cnt + 1) addr_ok = 1'b0;
                rd_cnt++;
            end
            if (done) early_done = 1'b1;
            start = (glitch && cyc == 2);
            step();
            cyc++;
        end
        start = 1'b0;
        check("latency", 128'(cyc), 128'(k + 4));
        check("rd_count", 128'(rd_cnt), 128'(k + 1));
        check("rd_addr_seq", 128'(addr_ok), 128'(1));
        check("early_done", 128'(early_done), 128'(0));
        check("result", res, exp);
        for (int h = 0; h < hold; h++) begin
            start = glitch;
            #1;
            check("hold_done", 128'(done), 128'(0));
            check("hold_valid", 128'(out_valid), 128'(1));
            check("hold_res", res, exp);
            check("hold_rd_en", 128'(rd_en), 128'(0));
            step();
        end
        start = 1'b0;
        out_ready = 1'b1;
        #1;
        check("done_pulse", 128'(done), 128'(1));
        step();
        out_ready = 1'b0;
        #1;
        check("post_valid", 128'(out_valid), 128'(0));
        check("post_busy", 128'(busy), 128'(0));
        check("post_done", 128'(done), 128'(0));
    endtask

    initial begin
        lane_vec_t zero_v;
        zero_v = '0;
        rst_n = 1'b0; start = 1'b0; k_len = '0; out_ready = 1'b0;
        a_q = '0; b_q = '0;
        step();
        step();
        check("rst_rd_en", 128'(rd_en), 128'(0));
        check("rst_addr", 128'({a_addr, b_addr}), 128'(0));
        check("rst_res", res, zero_v);
        check("rst_valid", 128'(out_valid), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_done", 128'(done), 128'(0));
        rst_n = 1'b1;
        step();

        do_run(0, 1, 0, 1'b0);
        do_run(3, 2, 1, 1'b0);
        do_run(1, 3, 0, 1'b0);
        do_run(2, 0, 5, 1'b0);
        do_run(4, 0, 3, 1'b1);
        do_run(1, 0, 0, 1'b0);
        step();
        step();
        check("no_stray_run", 128'(busy), 128'(0));

        // Reset in the middle of an 8-step run.
        fill(7, 0, zero_v);
        zero_v = '0;
        k_len = 8'd7;
        start = 1'b1;
        step();
        start = 1'b0;
        step(); step(); step();
        check("mid_addr", 128'(a_addr), 128'(3));
        rst_n = 1'b0;
        step();
        check("mrst_rd_en", 128'(rd_en), 128'(0));
        check("mrst_addr", 128'(a_addr), 128'(0));
        check("mrst_busy", 128'(busy), 128'(0));
        check("mrst_valid", 128'(out_valid), 128'(0));
        check("mrst_done", 128'(done), 128'(0));
        check("mrst_res", res, zero_v);
        rst_n = 1'b1;
        step();
        do_run(2, 0, 0, 1'b0);

        for (int r = 0; r < 6; r++) begin
            do_run(int'($urandom_range(0, 15)), 0, int'($urandom_range(0, 3)), r[0]);
        end
        do_run(255, 0, 1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
